// File: rtl/pcs_test_pkg.sv
// Shared types for the PCS PRBS31 loopback self-test sequencer.
package pcs_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RX_RST,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } pcs_test_state_t;

  localparam logic [2:0] FAIL_NONE      = 3'd0;
  localparam logic [2:0] FAIL_LOCK_TO   = 3'd1;
  localparam logic [2:0] FAIL_LOCK_LOST = 3'd2;
  localparam logic [2:0] FAIL_HIGH_BER  = 3'd3;
  localparam logic [2:0] FAIL_PRBS_ERR  = 3'd4;

endpackage

// File: rtl/pcs_sat_accum.sv
// Saturating accumulator with synchronous clear; clear wins over add.
module pcs_sat_accum #(
  parameter int W    = 16,
  parameter int IN_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [IN_W-1:0] din,
  output logic [W-1:0]    acc
);

  // One extra bit above the wider operand catches the carry out.
  localparam int SW = ((W > IN_W) ? W : IN_W) + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] sat_lim;

  assign sum     = SW'(acc) + SW'(din);
  assign sat_lim = SW'({W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             acc <= '0;
    else if (clr)           acc <= '0;
    else if (en) begin
      if (sum > sat_lim)    acc <= {W{1'b1}};
      else                  acc <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/pcs_prbs_loopback_ctrl.sv
// Sequencer for a line-loopback PRBS31 self-test of the 10G PHY:
// enable PRBS, settle, pulse RX reset, wait for lock, count errors, report.
module pcs_prbs_loopback_ctrl
  import pcs_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 6,
  parameter int RX_RST_CYCLES = 1,
  parameter int LOCK_TIMEOUT  = 64,
  parameter int RUN_CYCLES    = 140,
  parameter int ERR_ACC_WIDTH = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     rx_block_lock,
  input  logic                     rx_high_ber,
  input  logic [6:0]               rx_error_count,
  output logic                     cfg_tx_prbs31_enable,
  output logic                     cfg_rx_prbs31_enable,
  output logic                     rx_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [2:0]               fail_code,
  output logic [ERR_ACC_WIDTH-1:0] err_accum
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RXRST_LAST  = CNT_WIDTH'(RX_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_LAST    = CNT_WIDTH'(RUN_CYCLES - 1);

  pcs_test_state_t       state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  idle_like;
  logic                  acc_clr;
  logic                  acc_en;
  logic                  final_zero;

  assign idle_like  = (state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL);
  assign acc_clr    = abort || (idle_like && start);
  assign acc_en     = (state == ST_RUN);
  // The last RUN cycle's count lands in the accumulator on the same edge.
  assign final_zero = (err_accum == '0) && (rx_error_count == 7'd0);

  pcs_sat_accum #(.W(ERR_ACC_WIDTH), .IN_W(7)) u_err_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (rx_error_count),
    .acc   (err_accum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      cfg_tx_prbs31_enable <= 1'b0;
      cfg_rx_prbs31_enable <= 1'b0;
      rx_rst               <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      pass                 <= 1'b0;
      fail_code            <= FAIL_NONE;
    end else if (abort) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      cfg_tx_prbs31_enable <= 1'b0;
      cfg_rx_prbs31_enable <= 1'b0;
      rx_rst               <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      pass                 <= 1'b0;
      fail_code            <= FAIL_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            state                <= ST_SETTLE;
            cnt                  <= '0;
            cfg_tx_prbs31_enable <= 1'b1;
            cfg_rx_prbs31_enable <= 1'b1;
            busy                 <= 1'b1;
            pass                 <= 1'b0;
            fail_code            <= FAIL_NONE;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state  <= ST_RX_RST;
            cnt    <= '0;
            rx_rst <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_RX_RST: begin
          if (cnt == RXRST_LAST) begin
            state  <= ST_WAIT_LOCK;
            cnt    <= '0;
            rx_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (rx_block_lock && !rx_high_ber) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state     <= ST_FAIL;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= FAIL_LOCK_TO;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (!rx_block_lock || rx_high_ber || (cnt == RUN_LAST)) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            if (!rx_block_lock) begin
              state     <= ST_FAIL;
              fail_code <= FAIL_LOCK_LOST;
            end else if (rx_high_ber) begin
              state     <= ST_FAIL;
              fail_code <= FAIL_HIGH_BER;
            end else if (final_zero) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state     <= ST_FAIL;
              fail_code <= FAIL_PRBS_ERR;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_prbs_loopback_ctrl.sv
// Scoreboard bench: stimulus queues expected results, monitors check them on done.
module tb_pcs_prbs_loopback_ctrl;

  typedef struct {
    logic        pass;
    logic [2:0]  code;
    logic [15:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, lock, ber;
  logic [6:0]  errc;

  logic        tx_en, rx_en, rx_rst, busy, done, pass;
  logic [2:0]  fail_code;
  logic [15:0] err_accum;

  logic        tx_en8, rx_en8, rx_rst8, busy8, done8, pass8;
  logic [2:0]  fail_code8;
  logic [7:0]  err_accum8;

  exp_t q16[$];
  exp_t q8[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pcs_prbs_loopback_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rx_block_lock(lock), .rx_high_ber(ber), .rx_error_count(errc),
    .cfg_tx_prbs31_enable(tx_en), .cfg_rx_prbs31_enable(rx_en),
    .rx_rst(rx_rst), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .err_accum(err_accum)
  );

  pcs_prbs_loopback_ctrl #(.ERR_ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rx_block_lock(lock), .rx_high_ber(ber), .rx_error_count(errc),
    .cfg_tx_prbs31_enable(tx_en8), .cfg_rx_prbs31_enable(rx_en8),
    .rx_rst(rx_rst8), .busy(busy8), .done(done8), .pass(pass8),
    .fail_code(fail_code8), .err_accum(err_accum8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic [2:0] c, input logic [15:0] a16,
                      input logic [15:0] a8);
    exp_t e;
    e.pass = p; e.code = c; e.acc = a16;
    q16.push_back(e);
    e.acc = a8;
    q8.push_back(e);
  endtask

  // Start pulse, then walk SETTLE and RX_RST; returns one cycle into WAIT_LOCK.
  task automatic go_wait_lock();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_en", {30'd0, tx_en, rx_en}, 32'd3);
    repeat (5) tick();
    chk("settle_rxrst_lo", {31'd0, rx_rst}, 32'd0);
    tick();
    chk("rxrst_hi", {31'd0, rx_rst}, 32'd1);
    tick();
    chk("rxrst_fall", {31'd0, rx_rst}, 32'd0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      $display("FAIL wait_idle: busy still high after %0d cycles", n);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q16.size() == 0) begin
        chk("unexpected_done16", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("res16_pass", {31'd0, pass}, {31'd0, e.pass});
        chk("res16_code", {29'd0, fail_code}, {29'd0, e.code});
        chk("res16_acc", {16'd0, err_accum}, {16'd0, e.acc});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", {31'd0, done8}, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("res8_pass", {31'd0, pass8}, {31'd0, e.pass});
        chk("res8_code", {29'd0, fail_code8}, {29'd0, e.code});
        chk("res8_acc", {24'd0, err_accum8}, {16'd0, e.acc});
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    lock = 1'b0; ber = 1'b0; errc = 7'd0;
    repeat (2) tick();
    chk("reset_ctrl", {26'd0, tx_en, rx_en, rx_rst, busy, done, pass}, 32'd0);
    chk("reset_code", {29'd0, fail_code}, 32'd0);
    chk("reset_acc", {16'd0, err_accum}, 32'd0);
    chk("reset_acc8", {24'd0, err_accum8}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean link: lock rises in the third WAIT_LOCK cycle.
    push(1'b1, 3'd0, 16'd0, 16'd0);
    go_wait_lock();
    repeat (2) tick();
    lock = 1'b1;
    tick();
    wait_idle(n);
    chk("run_len", n, 32'd140);
    tick();
    chk("pass_hold", {28'd0, pass, done, tx_en, rx_en}, 32'b1011);

    // Five errors on three RUN cycles.
    push(1'b0, 3'd4, 16'd15, 16'd15);
    go_wait_lock();
    tick();
    errc = 7'd5;
    repeat (3) tick();
    errc = 7'd0;
    wait_idle(n);

    // No lock: timeout exactly 64 cycles after WAIT_LOCK entry.
    lock = 1'b0;
    push(1'b0, 3'd1, 16'd0, 16'd0);
    go_wait_lock();
    wait_idle(n);
    chk("lock_to_len", n, 32'd64);

    // Lock loss and high BER together; that cycle's 2 errors still count.
    push(1'b0, 3'd2, 16'd2, 16'd2);
    go_wait_lock();
    tick();
    lock = 1'b1;
    repeat (6) tick();
    lock = 1'b0; ber = 1'b1; errc = 7'd2;
    tick();
    ber = 1'b0; errc = 7'd0;
    wait_idle(n);
    chk("lost_en_hold", {30'd0, tx_en, rx_en}, 32'd3);

    // Saturation: 64 errors per RUN cycle, 140 cycles.
    lock = 1'b1; errc = 7'd64;
    push(1'b0, 3'd4, 16'd8960, 16'd255);
    go_wait_lock();
    wait_idle(n);
    errc = 7'd0;

    // Abort beats start in WAIT_LOCK.
    lock = 1'b0;
    go_wait_lock();
    repeat (2) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_ctrl", {27'd0, tx_en, rx_en, rx_rst, busy, pass}, 32'd0);
    chk("abort_code", {29'd0, fail_code}, 32'd0);
    chk("abort_acc", {16'd0, err_accum}, 32'd0);
    chk("abort_acc8", {24'd0, err_accum8}, 32'd0);
    repeat (3) tick();
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of RX_RST.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mid_rxrst_hi", {31'd0, rx_rst}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {29'd0, rx_rst, tx_en, rx_en}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Restart to a clean PASS.
    lock = 1'b1;
    push(1'b1, 3'd0, 16'd0, 16'd0);
    go_wait_lock();
    wait_idle(n);
    chk("restart_run_len", n, 32'd141);
    repeat (2) tick();
    chk("q_empty", q16.size() + q8.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
